// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI arbiter and its byte engine.
package sd_spi_pkg;

    // Byte engine states; the engine is idle between bytes.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } eng_state_t;

    // clk cycles per SCK half-period when the parent does not override it.
    localparam int CLK_DIV_DEFAULT = 2;

    // Bus levels while nothing is being transferred.
    localparam logic       SCK_IDLE    = 1'b0;
    localparam logic       MOSI_IDLE   = 1'b1;
    localparam logic       CS_N_IDLE   = 1'b1;
    localparam logic [7:0] RDATA_RESET = 8'hFF;

endpackage

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte engine: one LOAD cycle, 16*CLK_DIV SHIFT cycles, one DONE cycle.
module spi_byte_engine
    import sd_spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic [7:0] i_data,
    input  logic       i_miso,
    output logic       o_sck,
    output logic       o_mosi,
    output logic [7:0] o_rx,
    output logic       o_idle,
    output logic       o_active,
    output logic       o_done
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    eng_state_t r_state;
    eng_state_t w_state_next;
    logic [3:0] r_div;
    logic       r_phase;     // 0 = SCK low half, 1 = SCK high half
    logic [2:0] r_bit;
    logic [6:0] r_tx;        // bits still to send after the one on MOSI
    logic [7:0] r_rx;
    logic       r_sck;
    logic       r_mosi;
    logic       w_tick;
    logic       w_last_bit;

    assign w_tick     = (r_div == DIV_LAST);
    assign w_last_bit = (r_bit == 3'd7);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic: a byte ends on the falling SCK edge of bit 7.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (i_start) w_state_next = ST_LOAD;
            ST_LOAD:  w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_tick && r_phase && w_last_bit) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Divider, bit counter and shift registers; MOSI only moves as SCK falls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div   <= '0;
            r_phase <= 1'b0;
            r_bit   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_sck   <= SCK_IDLE;
            r_mosi  <= MOSI_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_div   <= '0;
                    r_phase <= 1'b0;
                    r_bit   <= '0;
                    r_sck   <= SCK_IDLE;
                    if (i_start) begin
                        r_tx   <= i_data[6:0];
                        r_mosi <= i_data[7];
                    end else begin
                        r_mosi <= MOSI_IDLE;
                    end
                end
                ST_LOAD: begin
                    r_div   <= '0;
                    r_phase <= 1'b0;
                    r_bit   <= '0;
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        r_div <= '0;
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                            r_sck   <= 1'b1;
                            r_rx    <= {r_rx[6:0], i_miso};
                        end else begin
                            r_phase <= 1'b0;
                            r_sck   <= 1'b0;
                            if (w_last_bit) begin
                                r_mosi <= MOSI_IDLE;
                            end else begin
                                r_bit  <= r_bit + 3'd1;
                                r_mosi <= r_tx[6];
                                r_tx   <= {r_tx[5:0], 1'b0};
                            end
                        end
                    end else begin
                        r_div <= r_div + 4'd1;
                    end
                end
                ST_DONE: begin
                    r_sck  <= SCK_IDLE;
                    r_mosi <= MOSI_IDLE;
                end
                default: begin
                    r_sck  <= SCK_IDLE;
                    r_mosi <= MOSI_IDLE;
                end
            endcase
        end
    end

    assign o_sck    = r_sck;
    assign o_mosi   = r_mosi;
    assign o_rx     = r_rx;
    assign o_idle   = (r_state == ST_IDLE);
    assign o_active = (r_state == ST_LOAD) || (r_state == ST_SHIFT);
    assign o_done   = (r_state == ST_DONE);

endmodule

// File: rtl/sd_spi_arbiter.sv
// Two-requester SD-card SPI arbiter: ownership, one-deep pending slots, result routing.
module sd_spi_arbiter
    import sd_spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int B_PRIO  = 1
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       a_cs_n,
    input  logic       a_req,
    input  logic [7:0] a_wdata,
    output logic [7:0] a_rdata,
    output logic       a_busy,
    output logic       a_ack,
    input  logic       b_cs_n,
    input  logic       b_req,
    input  logic [7:0] b_wdata,
    output logic [7:0] b_rdata,
    output logic       b_busy,
    output logic       b_ack,
    output logic       owner,
    output logic       owned,
    output logic       sd_cs_n,
    output logic       sd_sck,
    output logic       sd_mosi,
    input  logic       sd_miso
);

    // Requester index 0 = A, 1 = B.
    logic            r_owned;
    logic            r_owner;
    logic [1:0]      w_cs_n;
    logic [1:0]      w_req;
    logic [1:0][7:0] w_wdata;
    logic [1:0]      w_pend;
    logic [1:0][7:0] w_pdata;
    logic [1:0][7:0] w_rdata;
    logic [1:0]      w_is_owner;
    logic [1:0]      w_busy;
    logic [1:0]      w_req_ok;
    logic [1:0]      w_claim;
    logic [1:0]      w_ack;
    logic            w_other;
    logic            w_pick_b;
    logic            w_start;
    logic [7:0]      w_start_data;
    logic            w_release;
    logic            w_eng_idle;
    logic            w_eng_active;
    logic            w_eng_done;
    logic [7:0]      w_eng_rx;

    assign w_cs_n  = {b_cs_n, a_cs_n};
    assign w_req   = {b_req, a_req};
    assign w_wdata = {b_wdata, a_wdata};
    assign w_other = ~r_owner;

    // The owner starts a byte straight from its request, or from a byte parked earlier.
    assign w_start      = r_owned && w_eng_idle && (w_pend[r_owner] || w_req_ok[r_owner]);
    assign w_start_data = w_pend[r_owner] ? w_pdata[r_owner] : w_wdata[r_owner];

    // An owner request in IDLE starts a byte instead of releasing.
    assign w_release = r_owned && w_cs_n[r_owner] && w_eng_idle
                       && !w_pend[r_owner] && !w_req_ok[r_owner];

    assign w_pick_b = w_claim[1] && ((B_PRIO != 0) || !w_claim[0]);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            logic       r_pend;
            logic [7:0] r_pdata;
            logic [7:0] r_rdata;

            assign w_is_owner[gi] = r_owned && (r_owner == 1'(gi));
            assign w_busy[gi]     = r_pend || (w_is_owner[gi] && w_eng_active);
            assign w_req_ok[gi]   = w_req[gi] && !w_busy[gi];
            assign w_claim[gi]    = !w_cs_n[gi] || w_req_ok[gi] || r_pend;
            assign w_ack[gi]      = w_is_owner[gi] && w_eng_done;
            assign w_pend[gi]     = r_pend;
            assign w_pdata[gi]    = r_pdata;
            // The fresh byte shows on rdata in the same cycle as ack.
            assign w_rdata[gi]    = w_ack[gi] ? w_eng_rx : r_rdata;

            // Pending slot: parks a byte the engine cannot take right now.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pend  <= 1'b0;
                    r_pdata <= '0;
                end else if (w_start && w_is_owner[gi] && r_pend) begin
                    r_pend <= 1'b0;
                end else if (w_req_ok[gi] && !(w_is_owner[gi] && w_eng_idle)) begin
                    r_pend  <= 1'b1;
                    r_pdata <= w_wdata[gi];
                end
            end

            // Holds the last received byte; only this requester's completions touch it.
            always_ff @(posedge clk) begin
                if (reset)          r_rdata <= RDATA_RESET;
                else if (w_ack[gi]) r_rdata <= w_eng_rx;
            end
        end
    endgenerate

    // Ownership: claim when free, release or hand over when the owner is quiet.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owned <= 1'b0;
            r_owner <= 1'b0;
        end else if (!r_owned) begin
            if (|w_claim) begin
                r_owned <= 1'b1;
                r_owner <= w_pick_b;
            end
        end else if (w_release) begin
            if (w_claim[w_other]) r_owner <= w_other;
            else                  r_owned <= 1'b0;
        end
    end

    spi_byte_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_start),
        .i_data   (w_start_data),
        .i_miso   (sd_miso),
        .o_sck    (sd_sck),
        .o_mosi   (sd_mosi),
        .o_rx     (w_eng_rx),
        .o_idle   (w_eng_idle),
        .o_active (w_eng_active),
        .o_done   (w_eng_done)
    );

    assign sd_cs_n = r_owned ? w_cs_n[r_owner] : CS_N_IDLE;
    assign owner   = r_owner;
    assign owned   = r_owned;
    assign a_rdata = w_rdata[0];
    assign b_rdata = w_rdata[1];
    assign a_busy  = w_busy[0];
    assign b_busy  = w_busy[1];
    assign a_ack   = w_ack[0];
    assign b_ack   = w_ack[1];

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Directed bench for sd_spi_arbiter: CLK_DIV=2 instance with MISO loopback, CLK_DIV=1 instance with MISO low.
module tb_sd_spi_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_cs_n = 1'b1, a_req = 1'b0, b_cs_n = 1'b1, b_req = 1'b0;
    logic [7:0] a_wdata = 8'h00, b_wdata = 8'h00;
    logic [7:0] a_rdata, b_rdata;
    logic       a_busy, a_ack, b_busy, b_ack, owner, owned, sd_cs_n, sd_sck, sd_mosi, sd_miso;

    logic       d1_a_cs_n = 1'b1, d1_a_req = 1'b0;
    logic [7:0] d1_a_wdata = 8'h00;
    logic [7:0] d1_a_rdata, d1_b_rdata;
    logic       d1_a_busy, d1_a_ack, d1_b_busy, d1_b_ack, d1_owner, d1_owned;
    logic       d1_sd_cs_n, d1_sd_sck, d1_sd_mosi;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign sd_miso = sd_mosi;

    sd_spi_arbiter #(.CLK_DIV(2), .B_PRIO(1)) dut (
        .clk(clk), .reset(reset),
        .a_cs_n(a_cs_n), .a_req(a_req), .a_wdata(a_wdata), .a_rdata(a_rdata), .a_busy(a_busy), .a_ack(a_ack),
        .b_cs_n(b_cs_n), .b_req(b_req), .b_wdata(b_wdata), .b_rdata(b_rdata), .b_busy(b_busy), .b_ack(b_ack),
        .owner(owner), .owned(owned), .sd_cs_n(sd_cs_n), .sd_sck(sd_sck), .sd_mosi(sd_mosi), .sd_miso(sd_miso)
    );

    sd_spi_arbiter #(.CLK_DIV(1), .B_PRIO(1)) dut1 (
        .clk(clk), .reset(reset),
        .a_cs_n(d1_a_cs_n), .a_req(d1_a_req), .a_wdata(d1_a_wdata), .a_rdata(d1_a_rdata), .a_busy(d1_a_busy), .a_ack(d1_a_ack),
        .b_cs_n(1'b1), .b_req(1'b0), .b_wdata(8'h00), .b_rdata(d1_b_rdata), .b_busy(d1_b_busy), .b_ack(d1_b_ack),
        .owner(d1_owner), .owned(d1_owned), .sd_cs_n(d1_sd_cs_n), .sd_sck(d1_sd_sck), .sd_mosi(d1_sd_mosi), .sd_miso(1'b0)
    );

    // One full clock: outputs are then sampled and inputs driven on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_cs_n = 1'b1; a_req = 1'b0; b_cs_n = 1'b1; b_req = 1'b0;
        d1_a_cs_n = 1'b1; d1_a_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_cs_n = 1'b0;
        tick();
        checks++; if (owned !== 1'b0) begin errors++; $display("FAIL reset_owned: got %b want 0", owned); end
        checks++; if (owner !== 1'b0) begin errors++; $display("FAIL reset_owner: got %b want 0", owner); end
        checks++; if (sd_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", sd_cs_n); end
        checks++; if (sd_sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b want 0", sd_sck); end
        checks++; if (sd_mosi !== 1'b1) begin errors++; $display("FAIL reset_mosi: got %b want 1", sd_mosi); end
        checks++; if ({a_busy, b_busy, a_ack, b_ack} !== 4'b0000) begin errors++; $display("FAIL reset_busy_ack: got %b want 0000", {a_busy, b_busy, a_ack, b_ack}); end
        checks++; if (a_rdata !== 8'hFF || b_rdata !== 8'hFF) begin errors++; $display("FAIL reset_rdata: got %h/%h want ff/ff", a_rdata, b_rdata); end
        do_reset();
    endtask

    // A owns the card and sends A5 with MISO looped back.
    task automatic test_basic_transfer();
        int cyc, first_ack, acks;
        logic prev_sck;
        logic [7:0] bits, got_rd;
        a_cs_n = 1'b0;
        tick();
        tick();
        checks++; if (owned !== 1'b1 || owner !== 1'b0) begin errors++; $display("FAIL basic_claim: got owned=%b owner=%b want 1/0", owned, owner); end
        checks++; if (sd_cs_n !== 1'b0) begin errors++; $display("FAIL basic_cs_n: got %b want 0", sd_cs_n); end
        a_wdata = 8'hA5; a_req = 1'b1;
        cyc = 0; first_ack = -1; acks = 0; prev_sck = sd_sck; bits = 8'h00; got_rd = 8'h00;
        for (int i = 0; i < 60; i++) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                a_req = 1'b0;
                checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", a_busy); end
            end
            if (sd_sck === 1'b1 && prev_sck === 1'b0) bits = {bits[6:0], sd_mosi};
            prev_sck = sd_sck;
            if (a_ack === 1'b1) begin
                acks++;
                if (first_ack < 0) begin
                    first_ack = cyc;
                    got_rd = a_rdata;
                    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b want 0", a_busy); end
                end
            end
        end
        $display("xfer A wdata=a5 mosi=%h rdata=%h ack_cycle=%0d", bits, got_rd, first_ack);
        checks++; if (first_ack !== 34) begin errors++; $display("FAIL basic_latency: got %0d want 34", first_ack); end
        checks++; if (bits !== 8'hA5) begin errors++; $display("FAIL basic_mosi: got %h want a5", bits); end
        checks++; if (got_rd !== 8'hA5) begin errors++; $display("FAIL basic_rdata: got %h want a5", got_rd); end
        checks++; if (acks !== 1) begin errors++; $display("FAIL basic_ack_count: got %0d want 1", acks); end
        checks++; if (b_ack !== 1'b0 || b_rdata !== 8'hFF) begin errors++; $display("FAIL basic_b_untouched: got ack=%b rdata=%h want 0/ff", b_ack, b_rdata); end
    endtask

    // A second owner request while the first byte is in flight is dropped.
    task automatic test_busy_ignore();
        int acks;
        logic [7:0] got_rd;
        acks = 0; got_rd = 8'h00;
        a_wdata = 8'h5A; a_req = 1'b1;
        tick();
        a_req = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        a_wdata = 8'h11; a_req = 1'b1;
        tick();
        a_req = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (a_ack === 1'b1) begin acks++; got_rd = a_rdata; end
            tick();
        end
        $display("xfer A wdata=5a (second req 11 while busy) rdata=%h acks=%0d", got_rd, acks);
        checks++; if (acks !== 1) begin errors++; $display("FAIL busy_ack_count: got %0d want 1", acks); end
        checks++; if (got_rd !== 8'h5A) begin errors++; $display("FAIL busy_rdata: got %h want 5a", got_rd); end
        checks++; if (a_rdata !== 8'h5A) begin errors++; $display("FAIL busy_rdata_hold: got %h want 5a", a_rdata); end
    endtask

    // B's byte waits in its pending slot until A lets go of the card.
    task automatic test_pending();
        int sck_seen, a_acks, b_acks;
        logic [7:0] got_rd;
        sck_seen = 0; a_acks = 0; b_acks = 0; got_rd = 8'h00;
        b_cs_n = 1'b0;
        tick();
        checks++; if (owner !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL pend_before: got owner=%b b_busy=%b want 0/0", owner, b_busy); end
        b_wdata = 8'h3C; b_req = 1'b1;
        tick();
        b_req = 1'b0;
        checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL pend_busy: got %b want 1", b_busy); end
        for (int i = 0; i < 20; i++) begin
            if (sd_sck === 1'b1) sck_seen++;
            if (a_ack === 1'b1) a_acks++;
            if (b_ack === 1'b1) b_acks++;
            tick();
        end
        checks++; if (sck_seen !== 0 || owner !== 1'b0) begin errors++; $display("FAIL pend_wait: got sck_cycles=%0d owner=%b want 0/0", sck_seen, owner); end
        a_cs_n = 1'b1;
        tick();
        checks++; if (owned !== 1'b1 || owner !== 1'b1 || sd_cs_n !== 1'b0) begin errors++; $display("FAIL pend_handover: got owned=%b owner=%b cs_n=%b want 1/1/0", owned, owner, sd_cs_n); end
        for (int i = 0; i < 60; i++) begin
            if (a_ack === 1'b1) a_acks++;
            if (b_ack === 1'b1) begin b_acks++; got_rd = b_rdata; end
            tick();
        end
        $display("xfer B wdata=3c rdata=%h b_acks=%0d a_acks=%0d", got_rd, b_acks, a_acks);
        checks++; if (b_acks !== 1) begin errors++; $display("FAIL pend_b_acks: got %0d want 1", b_acks); end
        checks++; if (got_rd !== 8'h3C) begin errors++; $display("FAIL pend_b_rdata: got %h want 3c", got_rd); end
        checks++; if (a_acks !== 0 || a_rdata !== 8'h5A) begin errors++; $display("FAIL pend_a_untouched: got acks=%0d rdata=%h want 0/5a", a_acks, a_rdata); end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL pend_b_idle: got %b want 0", b_busy); end
    endtask

    // Both claim in the same cycle; B wins, A takes over when B lets go.
    task automatic test_simul_claim();
        do_reset();
        tick();
        a_cs_n = 1'b0; b_cs_n = 1'b0;
        tick();
        checks++; if (owned !== 1'b1 || owner !== 1'b1 || sd_cs_n !== 1'b0) begin errors++; $display("FAIL simul_grant: got owned=%b owner=%b cs_n=%b want 1/1/0", owned, owner, sd_cs_n); end
        tick();
        tick();
        checks++; if (owner !== 1'b1) begin errors++; $display("FAIL simul_hold: got owner=%b want 1", owner); end
        b_cs_n = 1'b1;
        #1;
        checks++; if (sd_cs_n !== 1'b1 || owner !== 1'b1) begin errors++; $display("FAIL simul_cs_follow: got cs_n=%b owner=%b want 1/1", sd_cs_n, owner); end
        tick();
        checks++; if (owned !== 1'b1 || owner !== 1'b0 || sd_cs_n !== 1'b0) begin errors++; $display("FAIL simul_handover: got owned=%b owner=%b cs_n=%b want 1/0/0", owned, owner, sd_cs_n); end
    endtask

    // Reset in the middle of bit 4 returns everything to idle with no ack.
    task automatic test_reset_mid_shift();
        int acks;
        acks = 0;
        do_reset();
        a_cs_n = 1'b0;
        tick();
        tick();
        a_wdata = 8'hC3; a_req = 1'b1;
        for (int cyc = 1; cyc <= 19; cyc++) begin
            tick();
            a_req = 1'b0;
        end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL rstmid_active: got busy=%b want 1", a_busy); end
        reset = 1'b1;
        tick();
        checks++; if (sd_sck !== 1'b0 || sd_mosi !== 1'b1 || sd_cs_n !== 1'b1) begin errors++; $display("FAIL rstmid_bus: got sck=%b mosi=%b cs_n=%b want 0/1/1", sd_sck, sd_mosi, sd_cs_n); end
        checks++; if (a_busy !== 1'b0 || a_ack !== 1'b0 || a_rdata !== 8'hFF) begin errors++; $display("FAIL rstmid_a: got busy=%b ack=%b rdata=%h want 0/0/ff", a_busy, a_ack, a_rdata); end
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (a_ack === 1'b1) acks++;
            tick();
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL rstmid_no_ack: got %0d want 0", acks); end
    endtask

    // CLK_DIV=1, MISO held low, all-ones byte out.
    task automatic test_div1();
        int cyc, first_ack;
        logic prev_sck;
        logic [7:0] bits, got_rd;
        do_reset();
        d1_a_cs_n = 1'b0;
        tick();
        tick();
        d1_a_wdata = 8'hFF; d1_a_req = 1'b1;
        cyc = 0; first_ack = -1; prev_sck = d1_sd_sck; bits = 8'h00; got_rd = 8'h55;
        for (int i = 0; i < 40; i++) begin
            tick();
            cyc++;
            d1_a_req = 1'b0;
            if (d1_sd_sck === 1'b1 && prev_sck === 1'b0) bits = {bits[6:0], d1_sd_mosi};
            prev_sck = d1_sd_sck;
            if (d1_a_ack === 1'b1 && first_ack < 0) begin first_ack = cyc; got_rd = d1_a_rdata; end
        end
        $display("xfer A(div1) wdata=ff mosi=%h rdata=%h ack_cycle=%0d", bits, got_rd, first_ack);
        checks++; if (first_ack !== 18) begin errors++; $display("FAIL div1_latency: got %0d want 18", first_ack); end
        checks++; if (got_rd !== 8'h00) begin errors++; $display("FAIL div1_rdata: got %h want 00", got_rd); end
        checks++; if (bits !== 8'hFF) begin errors++; $display("FAIL div1_mosi: got %h want ff", bits); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_transfer();
        test_busy_ignore();
        test_pending();
        test_simul_claim();
        test_reset_mid_shift();
        test_div1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
